// File: rtl/adder_pipe.sv
// Two-stage split-carry adder/subtractor/accumulator with valid/ready handshakes on both sides.
// Latency 2 cycles from input presentation to o_valid; 1 beat/cycle; stall holds o_X/o_valid, o_ready = !v1 || !v2 || i_ready.
module adder_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int LOW_WIDTH  = DATA_WIDTH / 2,
    parameter int GUARD_BITS = 2,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [1:0]                         i_mode,
    input  logic [DATA_WIDTH-1:0]              i_A,
    input  logic [DATA_WIDTH-1:0]              i_B,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [DATA_WIDTH+GUARD_BITS-1:0]   o_X,
    output logic                               o_ovf
);
    localparam int OUT_WIDTH  = DATA_WIDTH + GUARD_BITS;
    localparam int HIGH_WIDTH = DATA_WIDTH - LOW_WIDTH;
    localparam logic [OUT_WIDTH-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic                   v1_q, v1_d;
    mode_e                  mode1_q, mode1_d;
    logic [LOW_WIDTH-1:0]   lo1_q, lo1_d;
    logic                   c1_q, c1_d;
    logic [HIGH_WIDTH-1:0]  ahi1_q, ahi1_d;
    logic [HIGH_WIDTH-1:0]  bhi1_q, bhi1_d;
    logic                   v2_q, v2_d;
    logic [OUT_WIDTH-1:0]   x2_q, x2_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;

    logic                   accept;
    logic                   adv2;
    logic                   is_sub;
    logic [DATA_WIDTH-1:0]  b_eff;
    logic [LOW_WIDTH:0]     lo_sum;
    logic [OUT_WIDTH:0]     acc_sum;
    logic [HIGH_WIDTH:0]    hi_sum;
    logic [DATA_WIDTH:0]    add_res;
    logic [DATA_WIDTH:0]    sub_res;

    assign o_ready = !v1_q || !v2_q || i_ready;
    assign accept  = i_valid && o_ready;
    assign adv2    = v1_q && (!v2_q || i_ready);
    assign o_valid = v2_q;
    assign o_X     = x2_q;
    assign o_ovf   = ovf_q;

    // Subtraction is A + ~B + 1: B is inverted here and the +1 enters as the low-half carry-in.
    always_comb begin
        is_sub  = (i_mode == MODE_SUB);
        b_eff   = is_sub ? ~i_B : i_B;
        lo_sum  = {1'b0, i_A[LOW_WIDTH-1:0]} + {1'b0, b_eff[LOW_WIDTH-1:0]}
                + {{LOW_WIDTH{1'b0}}, is_sub};
        acc_sum = {1'b0, acc_q} + (OUT_WIDTH+1)'(i_A);
        hi_sum  = {1'b0, ahi1_q} + {1'b0, bhi1_q} + {{HIGH_WIDTH{1'b0}}, c1_q};
        add_res = {hi_sum, lo1_q};
        sub_res = {~hi_sum[HIGH_WIDTH], hi_sum[HIGH_WIDTH-1:0], lo1_q};
    end

    always_comb begin
        v1_d    = v1_q;
        mode1_d = mode1_q;
        lo1_d   = lo1_q;
        c1_d    = c1_q;
        ahi1_d  = ahi1_q;
        bhi1_d  = bhi1_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (accept) begin
            v1_d    = 1'b1;
            mode1_d = mode_e'(i_mode);
            lo1_d   = lo_sum[LOW_WIDTH-1:0];
            c1_d    = lo_sum[LOW_WIDTH];
            ahi1_d  = i_A[DATA_WIDTH-1:LOW_WIDTH];
            bhi1_d  = b_eff[DATA_WIDTH-1:LOW_WIDTH];
            if (i_mode == MODE_ACC) begin
                if (acc_sum[OUT_WIDTH]) begin
                    ovf_d = 1'b1;
                    acc_d = SATURATE ? ACC_MAX : acc_sum[OUT_WIDTH-1:0];
                end else begin
                    acc_d = acc_sum[OUT_WIDTH-1:0];
                end
            end else if (i_mode == MODE_LOAD) begin
                acc_d = OUT_WIDTH'(i_A);
                ovf_d = 1'b0;
            end
        end else if (adv2) begin
            v1_d = 1'b0;
        end
    end

    // An acc/load beat in stage 1 reads acc_q directly: acc_q can only change again on a
    // later accept, and that same edge always moves the stage-1 beat into stage 2.
    always_comb begin
        v2_d = v2_q;
        x2_d = x2_q;
        if (adv2) begin
            v2_d = 1'b1;
            case (mode1_q)
                MODE_ADD: x2_d = OUT_WIDTH'(add_res);
                MODE_SUB: x2_d = OUT_WIDTH'($signed(sub_res));
                default:  x2_d = acc_q;
            endcase
        end else if (i_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q    <= 1'b0;
            mode1_q <= MODE_ADD;
            lo1_q   <= '0;
            c1_q    <= 1'b0;
            ahi1_q  <= '0;
            bhi1_q  <= '0;
            v2_q    <= 1'b0;
            x2_q    <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            mode1_q <= mode1_d;
            lo1_q   <= lo1_d;
            c1_q    <= c1_d;
            ahi1_q  <= ahi1_d;
            bhi1_q  <= bhi1_d;
            v2_q    <= v2_d;
            x2_q    <= x2_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: a saturating and a wrapping instance share stimulus; a scoreboard
// with its own arithmetic model follows every handshake, plus directed vectors and corner sequences.
module tb_adder_pipe;
    localparam int MASK = 1023;

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_valid, i_ready;
    logic [1:0] i_mode;
    logic [7:0] i_A, i_B;
    logic       o_ready, o_valid, o_ovf;
    logic [9:0] o_X;
    logic       o_ready_w, o_valid_w, o_ovf_w;
    logic [9:0] o_X_w;

    always #5 i_clk = ~i_clk;

    adder_pipe #(.DATA_WIDTH(8), .LOW_WIDTH(4), .GUARD_BITS(2), .SATURATE(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_A(i_A), .i_B(i_B), .o_valid(o_valid), .i_ready(i_ready),
        .o_X(o_X), .o_ovf(o_ovf));

    adder_pipe #(.DATA_WIDTH(8), .LOW_WIDTH(4), .GUARD_BITS(2), .SATURATE(1'b0)) dut_w (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_w),
        .i_mode(i_mode), .i_A(i_A), .i_B(i_B), .o_valid(o_valid_w), .i_ready(i_ready),
        .o_X(o_X_w), .o_ovf(o_ovf_w));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: model state advances on every accept, results are compared on every take.
    typedef struct { int xs; int xw; } exp_t;
    exp_t       exp_q[$];
    int         m_acc_s, m_acc_w;
    bit         m_ovf_s, m_ovf_w;
    bit         hold;
    logic [9:0] hold_x;

    always @(negedge i_clk) begin
        exp_t e;
        int   ns, nw, xs, xw;
        if (!i_rst_n) begin
            exp_q.delete();
            m_acc_s = 0; m_acc_w = 0; m_ovf_s = 0; m_ovf_w = 0; hold = 0;
        end else begin
            chk("mon_ovf_s", 32'(o_ovf), 32'(m_ovf_s));
            chk("mon_ovf_w", 32'(o_ovf_w), 32'(m_ovf_w));
            chk("mon_rdy_w", 32'(o_ready_w), 32'(o_ready));
            if (hold) begin
                chk("mon_hold_vld", 32'(o_valid), 1);
                chk("mon_hold_x", 32'(o_X), 32'(hold_x));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) chk("mon_extra_beat", 32'(exp_q.size()), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("mon_x_s", 32'(o_X), 32'(e.xs));
                    chk("mon_x_w", 32'(o_X_w), 32'(e.xw));
                    chk("mon_vld_w", 32'(o_valid_w), 1);
                end
            end
            hold   = o_valid && !i_ready;
            hold_x = o_X;
            if (i_valid && o_ready) begin
                case (i_mode)
                    2'd0: begin xs = (int'(i_A) + int'(i_B)) & MASK; xw = xs; end
                    2'd1: begin xs = (int'(i_A) - int'(i_B)) & MASK; xw = xs; end
                    2'd2: begin
                        ns = m_acc_s + int'(i_A);
                        nw = m_acc_w + int'(i_A);
                        if (ns > MASK) begin m_ovf_s = 1; m_acc_s = MASK; end
                        else m_acc_s = ns;
                        if (nw > MASK) begin m_ovf_w = 1; m_acc_w = nw % (MASK + 1); end
                        else m_acc_w = nw;
                        xs = m_acc_s; xw = m_acc_w;
                    end
                    default: begin
                        m_acc_s = int'(i_A); m_acc_w = int'(i_A);
                        m_ovf_s = 0; m_ovf_w = 0;
                        xs = m_acc_s; xw = m_acc_w;
                    end
                endcase
                exp_q.push_back('{xs, xw});
            end
        end
    end

    typedef struct {
        logic [1:0] mode;
        int a, b;
        int xs; int os;
        int xw; int ow;
    } vec_t;
    vec_t vecs [18];

    task automatic run_vec(input vec_t v, input int idx);
        @(posedge i_clk); #1;
        i_valid = 1; i_mode = v.mode; i_A = 8'(v.a); i_B = 8'(v.b);
        @(posedge i_clk); #1;
        i_valid = 0;
        chk($sformatf("vec%0d_lat1", idx), 32'(o_valid), 0);
        @(posedge i_clk); #1;
        chk($sformatf("vec%0d_vld", idx), 32'(o_valid), 1);
        chk($sformatf("vec%0d_x_s", idx), 32'(o_X), 32'(v.xs));
        chk($sformatf("vec%0d_ovf_s", idx), 32'(o_ovf), 32'(v.os));
        chk($sformatf("vec%0d_x_w", idx), 32'(o_X_w), 32'(v.xw));
        chk($sformatf("vec%0d_ovf_w", idx), 32'(o_ovf_w), 32'(v.ow));
    endtask

    initial begin
        int   acc_n, got, stall, last_c, n_acc;
        bit   seen, take_ok;
        vec_t post;

        i_rst_n = 0; i_valid = 0; i_ready = 1; i_mode = 0; i_A = 0; i_B = 0;
        vecs[0]  = '{2'b00, 'hFF, 'hFF, 'h1FE, 0, 'h1FE, 0};
        vecs[1]  = '{2'b00, 'h0F, 'h01, 'h010, 0, 'h010, 0};
        vecs[2]  = '{2'b01, 'h05, 'h07, 'h3FE, 0, 'h3FE, 0};
        vecs[3]  = '{2'b01, 'h80, 'h00, 'h080, 0, 'h080, 0};
        vecs[4]  = '{2'b11, 'hFF, 'h00, 'h0FF, 0, 'h0FF, 0};
        vecs[5]  = '{2'b10, 'hFF, 'h33, 'h1FE, 0, 'h1FE, 0};
        vecs[6]  = '{2'b10, 'hFF, 'h00, 'h2FD, 0, 'h2FD, 0};
        vecs[7]  = '{2'b10, 'hFF, 'h00, 'h3FC, 0, 'h3FC, 0};
        vecs[8]  = '{2'b10, 'hFF, 'h00, 'h3FF, 1, 'h0FB, 1};
        vecs[9]  = '{2'b10, 'h01, 'h00, 'h3FF, 1, 'h0FC, 1};
        vecs[10] = '{2'b11, 'h00, 'h00, 'h000, 0, 'h000, 0};
        vecs[11] = '{2'b00, 'h00, 'h00, 'h000, 0, 'h000, 0};
        vecs[12] = '{2'b11, 'hFF, 'h00, 'h0FF, 0, 'h0FF, 0};
        vecs[13] = '{2'b10, 'hFF, 'h00, 'h1FE, 0, 'h1FE, 0};
        vecs[14] = '{2'b10, 'hFF, 'h00, 'h2FD, 0, 'h2FD, 0};
        vecs[15] = '{2'b10, 'hFF, 'h00, 'h3FC, 0, 'h3FC, 0};
        vecs[16] = '{2'b10, 'hFF, 'h00, 'h3FF, 1, 'h0FB, 1};
        vecs[17] = '{2'b10, 'h55, 'h00, 'h3FF, 1, 'h150, 1};

        #12;
        chk("rst_vld", 32'(o_valid), 0);
        chk("rst_x", 32'(o_X), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        chk("rst_rdy", 32'(o_ready), 1);
        @(posedge i_clk); #1;
        i_rst_n = 1;
        chk("post_rst_rdy", 32'(o_ready), 1);

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Reset with two beats stalled in the pipe and the wrapping accumulator at 0x150, ovf set.
        @(posedge i_clk); #1;
        i_ready = 0; i_valid = 1; i_mode = 2'b00; i_A = 8'd1; i_B = 8'd1;
        @(posedge i_clk); #1;
        i_A = 8'd2; i_B = 8'd2;
        @(posedge i_clk); #1;
        i_valid = 0;
        chk("mid_pre_vld", 32'(o_valid), 1);
        chk("mid_pre_rdy", 32'(o_ready), 0);
        chk("mid_pre_ovf_w", 32'(o_ovf_w), 1);
        #2 i_rst_n = 0;
        #1;
        chk("mid_rst_vld", 32'(o_valid), 0);
        chk("mid_rst_x", 32'(o_X), 0);
        chk("mid_rst_ovf", 32'(o_ovf), 0);
        chk("mid_rst_ovf_w", 32'(o_ovf_w), 0);
        chk("mid_rst_x_w", 32'(o_X_w), 0);
        chk("mid_rst_rdy", 32'(o_ready), 1);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst_n = 1; i_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            chk("mid_post_vld", 32'(o_valid), 0);
        end
        post = '{2'b10, 'h01, 'h00, 'h001, 0, 'h001, 0};
        run_vec(post, 99);

        // Back-pressure: stream 1+1..4+4 with the consumer stalled for 5 cycles.
        @(posedge i_clk); #1;
        acc_n = 0; got = 0; stall = 0; last_c = 0; seen = 0;
        i_valid = 1; i_mode = 2'b00; i_A = 8'd1; i_B = 8'd1; i_ready = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge i_clk);
            if (o_valid) seen = 1;
            if (seen && !i_ready) begin
                chk("bp_stall_x", 32'(o_X), 'h002);
                chk("bp_stall_rdy", 32'(o_ready), 0);
                chk("bp_stall_accepts", 32'(acc_n), 2);
                stall++;
            end
            if (o_valid && i_ready) begin
                chk($sformatf("bp_out%0d", got), 32'(o_X), 32'(2 * (got + 1)));
                if (got > 0) chk("bp_gap", 32'(c - last_c), 1);
                last_c = c;
                got++;
            end
            take_ok = i_valid && o_ready;
            @(posedge i_clk); #1;
            if (take_ok) begin
                acc_n++;
                if (acc_n == 4) i_valid = 0;
                else begin i_A = 8'(acc_n + 1); i_B = 8'(acc_n + 1); end
            end
            if (stall == 5) i_ready = 1;
        end
        chk("bp_count", 32'(got), 4);

        // Random modes, operands and handshake gaps against the scoreboard.
        n_acc = 0;
        for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_mode  = 2'($urandom_range(0, 3));
            i_A     = 8'($urandom_range(0, 255));
            i_B     = 8'($urandom_range(0, 255));
            @(negedge i_clk);
            if (i_valid && o_ready) n_acc++;
            @(posedge i_clk); #1;
        end
        chk("rand_accepted", 32'(n_acc), 1000);
        i_valid = 0; i_ready = 1;
        for (int k = 0; k < 10; k++) @(posedge i_clk);
        #1;
        chk("rand_drained", 32'(exp_q.size()), 0);
        chk("rand_idle_vld", 32'(o_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
